pulse_gate_divider_mc: RTL and testbench

Multi-channel, runtime-programmable pulse gate divider. Each channel counts qualified input pulses and emits a one-cycle output pulse every GATE pulses. Each channel runs in loop, one-shot or bypass mode. Sits in the AXI4 device timing path between trigger sources and downstream gate/acquisition logic; configuration comes from AXI-lite registers in the clk domain.

---
 rtl/pulse_div_pkg.sv | 14 +
 rtl/pulse_div_ch.sv | 126 ++++++++++++
 rtl/pulse_gate_divider_mc.sv | 45 ++++
 tb/tb_pulse_gate_divider_mc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_div_pkg.sv
// Shared encodings for the pulse gate divider: channel modes and FSM states.
package pulse_div_pkg;

    localparam logic [1:0] MODE_LOOP   = 2'd0;
    localparam logic [1:0] MODE_ONCE   = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_div_ch.sv
// One divider channel: optional rising-edge qualifier, IDLE/COUNT/DONE FSM,
// input-pulse counter and output-pulse counter. Mode and gate count are
// shadowed on the IDLE->COUNT transition so live config edits do not disturb
// a running count.
module pulse_div_ch
    import pulse_div_pkg::*;
#(
    parameter int CNT_BIT_WID = 32,
    parameter int OUT_CNT_WID = 16,
    parameter int EDGE_DET    = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   p_in,
    input  logic                   cfg_en,
    input  logic [1:0]             cfg_mode,
    input  logic [CNT_BIT_WID-1:0] cfg_gate_num,
    input  logic                   clr,
    output logic                   p_out,
    output logic                   done,
    output logic [CNT_BIT_WID-1:0] p_in_cnt,
    output logic [OUT_CNT_WID-1:0] p_out_cnt
);

    logic                   q;
    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [CNT_BIT_WID-1:0] gate_q, gate_d;
    logic [CNT_BIT_WID-1:0] cnt_q, cnt_d, cnt_inc;
    logic [OUT_CNT_WID-1:0] ocnt_q, ocnt_d;
    logic                   pout_q, pout_d;

    generate
        if (EDGE_DET != 0) begin : g_edge
            logic prev_q;
            logic prev_d;
            // Previous p_in sample for rising-edge qualification.
            always_comb prev_d = p_in;
            // History register, cleared by reset.
            always_ff @(posedge clk) begin
                if (!rstn) prev_q <= 1'b0;
                else       prev_q <= prev_d;
            end
            assign q = p_in & ~prev_q;
        end else begin : g_level
            assign q = p_in;
        end
    endgenerate

    // Next-state, counters and output pulse; clr beats cfg_en beats q.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        ocnt_d  = ocnt_q;
        pout_d  = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ocnt_d  = '0;
        end else if (!cfg_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (cfg_gate_num != '0) begin
                        state_d = ST_COUNT;
                        mode_d  = cfg_mode;
                        gate_d  = cfg_gate_num;
                    end
                end
                ST_COUNT: begin
                    if (mode_q == MODE_BYPASS) begin
                        pout_d = q;
                        cnt_d  = '0;
                        if (q) ocnt_d = ocnt_q + 1'b1;
                    end else if (q) begin
                        // Reserved mode 3 falls through here and behaves as loop.
                        if (cnt_inc == gate_q) begin
                            pout_d = 1'b1;
                            cnt_d  = '0;
                            ocnt_d = ocnt_q + 1'b1;
                            if (mode_q == MODE_ONCE) state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_DONE: cnt_d = '0;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LOOP;
            gate_q  <= '0;
            cnt_q   <= '0;
            ocnt_q  <= '0;
            pout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            ocnt_q  <= ocnt_d;
            pout_q  <= pout_d;
        end
    end

    assign p_out     = pout_q;
    assign done      = (state_q == ST_DONE);
    assign p_in_cnt  = cnt_q;
    assign p_out_cnt = ocnt_q;

endmodule

// File: rtl/pulse_gate_divider_mc.sv
// Multi-channel pulse gate divider: CH_NUM independent pulse_div_ch
// instances; this level only slices the flattened per-channel buses.
module pulse_gate_divider_mc #(
    parameter int CH_NUM      = 4,
    parameter int CNT_BIT_WID = 32,
    parameter int OUT_CNT_WID = 16,
    parameter int EDGE_DET    = 0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [CH_NUM-1:0]             p_in,
    input  logic [CH_NUM-1:0]             cfg_en,
    input  logic [2*CH_NUM-1:0]           cfg_mode,
    input  logic [CNT_BIT_WID*CH_NUM-1:0] cfg_gate_num,
    input  logic [CH_NUM-1:0]             clr,
    output logic [CH_NUM-1:0]             p_out,
    output logic [CH_NUM-1:0]             done,
    output logic [CNT_BIT_WID*CH_NUM-1:0] p_in_cnt,
    output logic [OUT_CNT_WID*CH_NUM-1:0] p_out_cnt
);

    genvar i;
    generate
        for (i = 0; i < CH_NUM; i++) begin : g_ch
            pulse_div_ch #(
                .CNT_BIT_WID (CNT_BIT_WID),
                .OUT_CNT_WID (OUT_CNT_WID),
                .EDGE_DET    (EDGE_DET)
            ) u_ch (
                .clk          (clk),
                .rstn         (rstn),
                .p_in         (p_in[i]),
                .cfg_en       (cfg_en[i]),
                .cfg_mode     (cfg_mode[2*i +: 2]),
                .cfg_gate_num (cfg_gate_num[CNT_BIT_WID*i +: CNT_BIT_WID]),
                .clr          (clr[i]),
                .p_out        (p_out[i]),
                .done         (done[i]),
                .p_in_cnt     (p_in_cnt[CNT_BIT_WID*i +: CNT_BIT_WID]),
                .p_out_cnt    (p_out_cnt[OUT_CNT_WID*i +: OUT_CNT_WID])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gate_divider_mc.sv
// Bench for pulse_gate_divider_mc: a level-counting and an edge-counting
// instance share all inputs. A reference model predicts every cycle's outputs
// into per-instance queues; a negedge monitor pops and compares.
module tb_pulse_gate_divider_mc;

    localparam int CH = 4;
    localparam int CW = 32;
    localparam int OW = 4;
    localparam int RW = 2*CH + CW*CH + OW*CH;

    // ---------------- clock / reset / stimulus signals ----------------
    logic clk = 1'b0;
    logic rstn;
    logic [CH-1:0]    p_in, cfg_en, clr;
    logic [2*CH-1:0]  cfg_mode;
    logic [CW*CH-1:0] cfg_gate_num;

    logic [CH-1:0]    po0, dn0, po1, dn1;
    logic [CW*CH-1:0] cnt0, cnt1;
    logic [OW*CH-1:0] oc0, oc1;

    always #5 clk = ~clk;

    pulse_gate_divider_mc #(.CH_NUM(CH), .CNT_BIT_WID(CW), .OUT_CNT_WID(OW), .EDGE_DET(0)) u_lvl (
        .clk(clk), .rstn(rstn), .p_in(p_in), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_gate_num(cfg_gate_num), .clr(clr), .p_out(po0), .done(dn0),
        .p_in_cnt(cnt0), .p_out_cnt(oc0));

    pulse_gate_divider_mc #(.CH_NUM(CH), .CNT_BIT_WID(CW), .OUT_CNT_WID(OW), .EDGE_DET(1)) u_edg (
        .clk(clk), .rstn(rstn), .p_in(p_in), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
        .cfg_gate_num(cfg_gate_num), .clr(clr), .p_out(po1), .done(dn1),
        .p_in_cnt(cnt1), .p_out_cnt(oc1));

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp0_q[$];
    logic [RW-1:0] exp1_q[$];

    function automatic logic [RW-1:0] pack(input logic [CH-1:0] po, input logic [CH-1:0] dn,
                                           input logic [CW*CH-1:0] cn, input logic [OW*CH-1:0] oc);
        return {po, dn, cn, oc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance d (0 level, 1 edge) and channel c: whether it is running,
    // whether a one-shot has finished, the pulse tally and the shadowed config.
    logic            m_run  [2][CH];
    logic            m_fin  [2][CH];
    logic            m_prev [2][CH];
    logic            m_po   [2][CH];
    logic [CW-1:0]   m_cnt  [2][CH];
    logic [CW-1:0]   m_n    [2][CH];
    logic [1:0]      m_md   [2][CH];
    logic [OW-1:0]   m_oc   [2][CH];
    logic            mq;
    logic [CH-1:0]    e_po, e_dn;
    logic [CW*CH-1:0] e_cn;
    logic [OW*CH-1:0] e_oc;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (!rstn) begin
                    m_run[d][c] = 0; m_fin[d][c] = 0; m_prev[d][c] = 0; m_po[d][c] = 0;
                    m_cnt[d][c] = 0; m_n[d][c] = 0; m_md[d][c] = 0; m_oc[d][c] = 0;
                end else begin
                    mq = (d == 1) ? (p_in[c] & ~m_prev[d][c]) : p_in[c];
                    m_prev[d][c] = p_in[c];
                    m_po[d][c] = 0;
                    if (clr[c]) begin
                        m_run[d][c] = 0; m_fin[d][c] = 0; m_cnt[d][c] = 0; m_oc[d][c] = 0;
                    end else if (!cfg_en[c]) begin
                        m_run[d][c] = 0; m_fin[d][c] = 0; m_cnt[d][c] = 0;
                    end else if (m_fin[d][c]) begin
                        m_cnt[d][c] = 0;
                    end else if (!m_run[d][c]) begin
                        if (cfg_gate_num[c*CW +: CW] != 0) begin
                            m_run[d][c] = 1;
                            m_n[d][c]   = cfg_gate_num[c*CW +: CW];
                            m_md[d][c]  = cfg_mode[2*c +: 2];
                        end
                    end else if (m_md[d][c] == 2'd2) begin
                        m_po[d][c] = mq;
                        if (mq) m_oc[d][c] = m_oc[d][c] + 1;
                    end else if (mq) begin
                        if (m_cnt[d][c] + 1 == m_n[d][c]) begin
                            m_po[d][c]  = 1;
                            m_cnt[d][c] = 0;
                            m_oc[d][c]  = m_oc[d][c] + 1;
                            if (m_md[d][c] == 2'd1) begin
                                m_run[d][c] = 0;
                                m_fin[d][c] = 1;
                            end
                        end else begin
                            m_cnt[d][c] = m_cnt[d][c] + 1;
                        end
                    end
                end
                e_po[c] = m_po[d][c];
                e_dn[c] = m_fin[d][c];
                e_cn[c*CW +: CW] = m_cnt[d][c];
                e_oc[c*OW +: OW] = m_oc[d][c];
            end
            if (d == 0) exp0_q.push_back(pack(e_po, e_dn, e_cn, e_oc));
            else        exp1_q.push_back(pack(e_po, e_dn, e_cn, e_oc));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp0_q.size() > 0) chk_rec("lvl_outputs", pack(po0, dn0, cnt0, oc0), exp0_q.pop_front());
        if (exp1_q.size() > 0) chk_rec("edge_outputs", pack(po1, dn1, cnt1, oc1), exp1_q.pop_front());
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ch0(input int n);
        for (int k = 0; k < n; k++) begin
            p_in[0] = 1'b1; tick(1);
            p_in[0] = 1'b0; tick(1);
        end
    endtask

    initial begin
        rstn = 1'b0; p_in = '0; cfg_en = '0; clr = '0; cfg_mode = '0; cfg_gate_num = '0;
        for (int k = 0; k < 3; k++) begin
            p_in = CH'($urandom); tick(1);
        end
        rstn = 1'b1; p_in = '0; tick(1);
        chk("reset_flags", {24'd0, po0, dn0}, 32'd0);
        chk("reset_counts", {31'd0, (cnt0 != '0) || (oc0 != '0)}, 32'd0);

        // Disabled: 20 pulses must produce nothing.
        for (int k = 0; k < 40; k++) begin
            p_in = (k % 2 == 0) ? '1 : '0; tick(1);
        end
        chk("disabled_ocnt", {16'd0, oc0}, 32'd0);

        // ch0 loop N=4, ch1 loop N=2, ch2 once N=3, ch3 bypass.
        p_in = '0;
        cfg_mode = {2'd2, 2'd1, 2'd0, 2'd0};
        cfg_gate_num = {32'd1, 32'd3, 32'd2, 32'd4};
        cfg_en = '1;
        tick(1);
        for (int t = 0; t < 36; t++) begin
            p_in[0] = (t % 3 == 0);
            p_in[1] = (t < 10);
            p_in[2] = (t < 10);
            p_in[3] = 1'($urandom);
            tick(1);
        end
        p_in = '0; tick(2);
        chk("loop4_ocnt", {28'd0, oc0[3:0]}, 32'd3);
        chk("loop4_cnt", cnt0[31:0], 32'd0);
        chk("b2b_ocnt", {28'd0, oc0[7:4]}, 32'd5);
        chk("once_done", {31'd0, dn0[2]}, 32'd1);
        chk("once_ocnt", {28'd0, oc0[11:8]}, 32'd1);
        chk("edge_held_cnt", cnt1[63:32], 32'd1);

        // clr with a simultaneous pulse on ch2.
        clr = 4'b0100; p_in = 4'b0100; tick(1);
        clr = '0; p_in = '0;
        chk("clr_done", {31'd0, dn0[2]}, 32'd0);
        chk("clr_cnt", cnt0[95:64], 32'd0);
        chk("clr_ocnt", {28'd0, oc0[11:8]}, 32'd0);

        // Config latching on ch0: N=5 latched, then live edit to 2.
        cfg_en[0] = 1'b0; tick(1);
        cfg_en[0] = 1'b1; cfg_gate_num[31:0] = 32'd5; tick(1);
        pulse_ch0(2);
        cfg_gate_num[31:0] = 32'd2;
        pulse_ch0(3);
        chk("latch_ocnt", {28'd0, oc0[3:0]}, 32'd4);
        pulse_ch0(3);
        chk("mid_cnt", cnt0[31:0], 32'd3);
        cfg_en[0] = 1'b0; tick(1);
        chk("drop_cnt", cnt0[31:0], 32'd0);
        chk("drop_ocnt", {28'd0, oc0[3:0]}, 32'd4);

        // N=0 never starts.
        cfg_gate_num[31:0] = 32'd0; cfg_en[0] = 1'b1; tick(1);
        pulse_ch0(4);
        chk("n0_ocnt", {28'd0, oc0[3:0]}, 32'd4);
        chk("n0_cnt", cnt0[31:0], 32'd0);

        // N=1 on ch1 with p_in held high: one output per cycle.
        cfg_en[1] = 1'b0; tick(1);
        cfg_gate_num[63:32] = 32'd1; cfg_en[1] = 1'b1; tick(1);
        p_in[1] = 1'b1; tick(5);
        p_in[1] = 1'b0; tick(1);
        chk("n1_ocnt", {28'd0, oc0[7:4]}, 32'd10);

        // Randomized traffic across all channels.
        for (int t = 0; t < 1500; t++) begin
            p_in = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                clr[c] = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 29) == 0) begin
                    cfg_en[c] = ($urandom_range(0, 7) != 0);
                    cfg_mode[2*c +: 2] = 2'($urandom_range(0, 3));
                    cfg_gate_num[c*CW +: CW] = $urandom_range(0, 4);
                end
            end
            rstn = !(t >= 700 && t < 702);
            tick(1);
        end
        p_in = '0; clr = '0; rstn = 1'b1;
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
